display_arbiter: RTL
====================

Name: display_arbiter

Overview:
- Shares the single 4-digit seven-segment display driver (display16bits) among four on-chip requesters, e.g. PC, instruction, ALU result and memory data.
- Round-robin arbitration with a minimum dwell time per grant, so each value stays readable.
- Registered 16-bit digit word output feeds display16bits.digit directly.

Parameters:
- DWELL_CYCLES, 25000000: minimum cycles a grant is held (0.5 s at 50 MHz). Legal range 1 to 2^32-1.
- DEFAULT_VALUE, 16'h0000: word shown when no source is granted.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  per-source display request, level-sensitive; bit i = source i.
- data  input  64  packed source words; source i on data[16*i+15:16*i].
- gnt  output  4  one-hot grant, registered; 0 when idle.
- src  output  2  index of the granted or last-granted source.
- busy  output  1  high while in GRANT (or MANUAL).
- switch_p  output  1  one-cycle pulse when gnt changes to a different nonzero value.
- digit  output  16  word for display16bits.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, gnt=0, src=0, busy=0, switch_p=0, digit=DEFAULT_VALUE.
  - dwell counter=0, round-robin pointer last=3, so source 0 has first priority.
- States: IDLE, GRANT (plus MANUAL under the optional feature).
- Round-robin pick: search from last+1 upward mod 4 and take the first set req bit.
- IDLE:
  - If req!=0 in cycle t, then at t+1: state=GRANT, gnt=onehot(pick), src=last=pick, digit=data[pick] as sampled at t, counter=0, busy=1, switch_p=1.
  - If req==0, stay in IDLE with digit=DEFAULT_VALUE.
- GRANT, digit update:
  - While req[src]=1, digit tracks data[src] with 1-cycle latency.
  - If req[src] drops before dwell expiry, digit freezes at its last value and gnt stays asserted until expiry.
- GRANT, dwell counter:
  - Increments every cycle.
  - Expiry is the cycle where counter==DWELL_CYCLES-1. Arithmetic is 32-bit unsigned and never wraps, because it is cleared at expiry.
- At expiry, with requests sampled in the same cycle:
  - Another source requesting: grant moves directly to pick at the next cycle, with no idle gap. switch_p=1, counter=0, digit=data[pick].
  - Only the current source requesting: grant is retained, counter restarts at 0, switch_p=0.
  - req==0: next cycle state=IDLE, gnt=0, busy=0, digit=DEFAULT_VALUE. src and last are kept.
- New requests arriving mid-dwell never preempt the current grant; they are arbitrated only at expiry.
- DWELL_CYCLES=1: every cycle is an expiry, so arbitration is pure per-cycle round-robin.
- All four requesting continuously: grant order 0,1,2,3,0,..., each held exactly DWELL_CYCLES cycles.
- Reset asserted mid-grant forces reset values immediately; no grant survives reset.
- gnt is always one-hot or zero. switch_p is never high in IDLE.

Optional Feature:
- Macro: DISPLAY_ARBITER_MANUAL_EN.
- When defined, adds inputs man_en (1 bit) and man_sel (2 bits), intended for board switches.
- man_en=1, sampled in any state, at the next cycle:
  - state=MANUAL, gnt=0, busy=1, src=man_sel.
  - digit=data[man_sel], tracked every cycle regardless of req.
  - Dwell counter held at 0.
- man_en falling: next state=IDLE and digit=DEFAULT_VALUE; arbitration resumes with last unchanged.
- Not defined: the ports are absent, the MANUAL state does not exist, and behaviour equals man_en tied 0.

Test Plan (DWELL_CYCLES=4 for simulation):
- Reset release, req=0 → digit=16'h0000, gnt=0, busy=0 for 10 cycles.
- req=4'b0100, data[47:32]=16'hBEEF at cycle t → at t+1 gnt=4'b0100, src=2, digit=16'hBEEF, switch_p=1 for one cycle. Change data to 16'h1234 → digit=16'h1234 one cycle later.
- req=4'b1111 held → gnt sequence 0001,0010,0100,1000,0001, each value for exactly 4 cycles; switch_p pulses at each change.
- Grant source 1 (data 16'h0A0A), drop req[1] after 1 cycle with no other requests → digit holds 16'h0A0A and gnt=4'b0010 for the full 4 cycles, then IDLE with digit=16'h0000.
- Only req[3] held for 12 cycles → gnt=4'b1000 throughout, no switch_p, counter restarts at each expiry. Pulse rst_n low mid-grant → gnt=0 and digit=16'h0000 immediately.
- With DISPLAY_ARBITER_MANUAL_EN defined: man_en=1, man_sel=2, req=4'b0001 → next cycle gnt=0, digit=data[47:32]. Release man_en → IDLE, then grant goes to source 0.

Source files
------------

// File: rtl/display_arbiter.sv
// Round-robin sharer of one 4-digit seven-segment driver among four requesters, with minimum dwell.
// Optional manual override (man_en/man_sel) is compiled in with DISPLAY_ARBITER_MANUAL_EN.
module display_arbiter #(
  parameter int unsigned DWELL_CYCLES  = 25000000,
  parameter logic [15:0] DEFAULT_VALUE = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [63:0] data,
`ifdef DISPLAY_ARBITER_MANUAL_EN
  input  logic        man_en,
  input  logic [1:0]  man_sel,
`endif
  output logic [3:0]  gnt,
  output logic [1:0]  src,
  output logic        busy,
  output logic        switch_p,
  output logic [15:0] digit
);

  typedef enum logic [1:0] {
    StIdle,
`ifdef DISPLAY_ARBITER_MANUAL_EN
    StManual,
`endif
    StGrant
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [1:0]  src_q, src_d;
  logic [1:0]  last_q, last_d;
  logic        busy_q, busy_d;
  logic        switch_p_q, switch_p_d;
  logic [15:0] digit_q, digit_d;
  logic [31:0] cnt_q, cnt_d;

  logic        pick_valid;
  logic [1:0]  pick_idx;
  logic [1:0]  cand;
  logic        expiry;

  // First requester strictly after last_q, wrapping; last_q itself is tried last.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = last_q;
    cand       = last_q;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign expiry = (cnt_q == DWELL_CYCLES - 32'd1);

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    src_d      = src_q;
    last_d     = last_q;
    busy_d     = busy_q;
    switch_p_d = 1'b0;
    digit_d    = digit_q;
    cnt_d      = cnt_q;
`ifdef DISPLAY_ARBITER_MANUAL_EN
    if (man_en) begin
      state_d = StManual;
      gnt_d   = 4'b0000;
      busy_d  = 1'b1;
      src_d   = man_sel;
      digit_d = data[{man_sel, 4'b0000} +: 16];
      cnt_d   = 32'd0;
    end else begin
`else
    begin
`endif
      unique case (state_q)
        StIdle: begin
          if (pick_valid) begin
            state_d    = StGrant;
            gnt_d      = 4'b0001 << pick_idx;
            src_d      = pick_idx;
            last_d     = pick_idx;
            busy_d     = 1'b1;
            switch_p_d = 1'b1;
            digit_d    = data[{pick_idx, 4'b0000} +: 16];
            cnt_d      = 32'd0;
          end else begin
            gnt_d   = 4'b0000;
            busy_d  = 1'b0;
            digit_d = DEFAULT_VALUE;
          end
        end
        StGrant: begin
          if (expiry) begin
            cnt_d = 32'd0;
            if (pick_valid) begin
              gnt_d      = 4'b0001 << pick_idx;
              src_d      = pick_idx;
              last_d     = pick_idx;
              switch_p_d = (pick_idx != src_q);
              digit_d    = data[{pick_idx, 4'b0000} +: 16];
            end else begin
              state_d = StIdle;
              gnt_d   = 4'b0000;
              busy_d  = 1'b0;
              digit_d = DEFAULT_VALUE;
            end
          end else begin
            cnt_d = cnt_q + 32'd1;
            // A dropped request freezes the shown word until the dwell runs out.
            if (req[src_q]) digit_d = data[{src_q, 4'b0000} +: 16];
          end
        end
`ifdef DISPLAY_ARBITER_MANUAL_EN
        StManual: begin
          state_d = StIdle;
          gnt_d   = 4'b0000;
          busy_d  = 1'b0;
          digit_d = DEFAULT_VALUE;
          cnt_d   = 32'd0;
        end
`endif
        default: begin
          state_d = StIdle;
          gnt_d   = 4'b0000;
          busy_d  = 1'b0;
          digit_d = DEFAULT_VALUE;
          cnt_d   = 32'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      gnt_q      <= 4'b0000;
      src_q      <= 2'd0;
      last_q     <= 2'd3;
      busy_q     <= 1'b0;
      switch_p_q <= 1'b0;
      digit_q    <= DEFAULT_VALUE;
      cnt_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      src_q      <= src_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      switch_p_q <= switch_p_d;
      digit_q    <= digit_d;
      cnt_q      <= cnt_d;
    end
  end

  assign gnt      = gnt_q;
  assign src      = src_q;
  assign busy     = busy_q;
  assign switch_p = switch_p_q;
  assign digit    = digit_q;

endmodule
